player_frame_sched: RTL and testbench

Per-frame game-state sequencer between the VGA timing generator and the pixel generator. Once per frame, at the start of vertical blanking, it snapshots the player buttons. It then runs a short fixed update sequence (player move, shot spawn, bullet advance) and commits the new player and bullet positions atomically. The pixel generator therefore never sees a position change mid-frame.

---
 rtl/player_frame_sched_if.sv | 29 ++
 rtl/player_frame_sched.sv | 223 ++++++++++++++++++++++
 tb/tb_player_frame_sched.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/player_frame_sched_if.sv
// Signal bundle between the VGA timing generator / button inputs and the
// per-frame game-state sequencer, plus the committed state it publishes.
interface player_frame_sched_if;
   logic       p_tick;
   logic [9:0] x;
   logic [9:0] y;
   logic       up;
   logic       down;
   logic       left;
   logic       right;
   logic       shot;
   logic [9:0] player_x;
   logic [9:0] player_y;
   logic [9:0] bullet_x;
   logic [9:0] bullet_y;
   logic       bullet_active;
   logic       frame_tick;
   logic       busy;

   modport master (
      output p_tick, x, y, up, down, left, right, shot,
      input  player_x, player_y, bullet_x, bullet_y, bullet_active, frame_tick, busy
   );

   modport slave (
      input  p_tick, x, y, up, down, left, right, shot,
      output player_x, player_y, bullet_x, bullet_y, bullet_active, frame_tick, busy
   );
endinterface

// File: rtl/player_frame_sched.sv
// Once per frame, at the start of vertical blank, snapshots the buttons, runs a
// fixed move/shot/bullet sequence on shadow registers and commits it atomically.
module player_frame_sched #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int PLAYER_SIZE = 16,
   parameter int PLAYER_STEP = 2,
   parameter int PLAYER_X0   = 312,
   parameter int PLAYER_Y0   = 448,
   parameter int BULLET_W    = 4,
   parameter int BULLET_H    = 8,
   parameter int BULLET_STEP = 4
) (
   input logic                 clk_50MHz,
   input logic                 reset,
   player_frame_sched_if.slave bus
);

   localparam logic [10:0] H_LIM    = 11'(H_ACTIVE);
   localparam logic [10:0] V_LIM    = 11'(V_ACTIVE);
   localparam logic [10:0] P_SIZE   = 11'(PLAYER_SIZE);
   localparam logic [10:0] P_STEP   = 11'(PLAYER_STEP);
   localparam logic [9:0]  V_ACT10  = 10'(V_ACTIVE);
   localparam logic [9:0]  X0       = 10'(PLAYER_X0);
   localparam logic [9:0]  Y0       = 10'(PLAYER_Y0);
   localparam logic [9:0]  B_XOFF   = 10'(PLAYER_SIZE / 2 - BULLET_W / 2);
   localparam logic [9:0]  B_H10    = 10'(BULLET_H);
   localparam logic [9:0]  B_STEP10 = 10'(BULLET_STEP);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_MOVE_X = 3'd1,
      S_MOVE_Y = 3'd2,
      S_SHOT   = 3'd3,
      S_BULLET = 3'd4,
      S_COMMIT = 3'd5
   } state_t;

   // One axis step with saturation at 0 and at limit-PLAYER_SIZE; opposing
   // buttons cancel. Sums are widened to 11 bits so they cannot wrap.
   function automatic logic [9:0] step_axis(input logic [9:0]  pos,
                                            input logic        dec,
                                            input logic        inc,
                                            input logic [10:0] limit);
      logic [10:0] p;
      logic [9:0]  r;
      p = {1'b0, pos};
      if (dec && !inc) begin
         r = (p >= P_STEP) ? 10'(p - P_STEP) : 10'd0;
      end else if (inc && !dec) begin
         r = (p + P_SIZE + P_STEP <= limit) ? 10'(p + P_STEP) : 10'(limit - P_SIZE);
      end else begin
         r = pos;
      end
      return r;
   endfunction

   state_t     state_q, state_d;
   logic       frame_tick_q, frame_tick_d;
   logic       busy_q, busy_d;
   logic       up_snap_q, up_snap_d;
   logic       down_snap_q, down_snap_d;
   logic       left_snap_q, left_snap_d;
   logic       right_snap_q, right_snap_d;
   logic       shot_snap_q, shot_snap_d;
   logic       shot_prev_q, shot_prev_d;
   logic [9:0] sh_px_q, sh_px_d;
   logic [9:0] sh_py_q, sh_py_d;
   logic [9:0] sh_bx_q, sh_bx_d;
   logic [9:0] sh_by_q, sh_by_d;
   logic       sh_act_q, sh_act_d;
   logic       spawned_q, spawned_d;
   logic [9:0] player_x_q, player_x_d;
   logic [9:0] player_y_q, player_y_d;
   logic [9:0] bullet_x_q, bullet_x_d;
   logic [9:0] bullet_y_q, bullet_y_d;
   logic       bullet_active_q, bullet_active_d;
   logic       spawn_ok_s;

   // Rising edge of the fire snapshot, only with no live bullet and room above.
   assign spawn_ok_s = shot_snap_q & ~shot_prev_q & ~sh_act_q & (sh_py_q >= B_H10);

   // Next-state and datapath for the frame update sequence.
   always_comb begin
      state_d         = state_q;
      up_snap_d       = up_snap_q;
      down_snap_d     = down_snap_q;
      left_snap_d     = left_snap_q;
      right_snap_d    = right_snap_q;
      shot_snap_d     = shot_snap_q;
      shot_prev_d     = shot_prev_q;
      sh_px_d         = sh_px_q;
      sh_py_d         = sh_py_q;
      sh_bx_d         = sh_bx_q;
      sh_by_d         = sh_by_q;
      sh_act_d        = sh_act_q;
      spawned_d       = spawned_q;
      player_x_d      = player_x_q;
      player_y_d      = player_y_q;
      bullet_x_d      = bullet_x_q;
      bullet_y_d      = bullet_y_q;
      bullet_active_d = bullet_active_q;
      frame_tick_d    = bus.p_tick & (bus.x == 10'd0) & (bus.y == V_ACT10);

      case (state_q)
         S_IDLE: begin
            if (frame_tick_q) begin
               state_d      = S_MOVE_X;
               up_snap_d    = bus.up;
               down_snap_d  = bus.down;
               left_snap_d  = bus.left;
               right_snap_d = bus.right;
               shot_snap_d  = bus.shot;
               shot_prev_d  = shot_snap_q;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_MOVE_X: begin
            sh_px_d = step_axis(sh_px_q, left_snap_q, right_snap_q, H_LIM);
            state_d = S_MOVE_Y;
         end
         S_MOVE_Y: begin
            sh_py_d = step_axis(sh_py_q, up_snap_q, down_snap_q, V_LIM);
            state_d = S_SHOT;
         end
         S_SHOT: begin
            // sh_px/sh_py already hold this frame's moved position here.
            if (spawn_ok_s) begin
               sh_bx_d   = sh_px_q + B_XOFF;
               sh_by_d   = sh_py_q - B_H10;
               sh_act_d  = 1'b1;
               spawned_d = 1'b1;
            end else begin
               spawned_d = spawned_q;
            end
            state_d = S_BULLET;
         end
         S_BULLET: begin
            if (sh_act_q && !spawned_q) begin
               if (sh_by_q >= B_STEP10) begin
                  sh_by_d = sh_by_q - B_STEP10;
               end else begin
                  sh_act_d = 1'b0;
               end
            end else begin
               sh_act_d = sh_act_q;
            end
            state_d = S_COMMIT;
         end
         S_COMMIT: begin
            player_x_d      = sh_px_q;
            player_y_d      = sh_py_q;
            bullet_x_d      = sh_bx_q;
            bullet_y_d      = sh_by_q;
            bullet_active_d = sh_act_q;
            spawned_d       = 1'b0;
            state_d         = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State, snapshot, shadow and output registers with synchronous reset.
   always_ff @(posedge clk_50MHz) begin
      if (!reset) begin
         state_q         <= S_IDLE;
         frame_tick_q    <= 1'b0;
         busy_q          <= 1'b0;
         up_snap_q       <= 1'b0;
         down_snap_q     <= 1'b0;
         left_snap_q     <= 1'b0;
         right_snap_q    <= 1'b0;
         shot_snap_q     <= 1'b0;
         shot_prev_q     <= 1'b0;
         sh_px_q         <= X0;
         sh_py_q         <= Y0;
         sh_bx_q         <= 10'd0;
         sh_by_q         <= 10'd0;
         sh_act_q        <= 1'b0;
         spawned_q       <= 1'b0;
         player_x_q      <= X0;
         player_y_q      <= Y0;
         bullet_x_q      <= 10'd0;
         bullet_y_q      <= 10'd0;
         bullet_active_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         frame_tick_q    <= frame_tick_d;
         busy_q          <= busy_d;
         up_snap_q       <= up_snap_d;
         down_snap_q     <= down_snap_d;
         left_snap_q     <= left_snap_d;
         right_snap_q    <= right_snap_d;
         shot_snap_q     <= shot_snap_d;
         shot_prev_q     <= shot_prev_d;
         sh_px_q         <= sh_px_d;
         sh_py_q         <= sh_py_d;
         sh_bx_q         <= sh_bx_d;
         sh_by_q         <= sh_by_d;
         sh_act_q        <= sh_act_d;
         spawned_q       <= spawned_d;
         player_x_q      <= player_x_d;
         player_y_q      <= player_y_d;
         bullet_x_q      <= bullet_x_d;
         bullet_y_q      <= bullet_y_d;
         bullet_active_q <= bullet_active_d;
      end
   end

   assign bus.player_x      = player_x_q;
   assign bus.player_y      = player_y_q;
   assign bus.bullet_x      = bullet_x_q;
   assign bus.bullet_y      = bullet_y_q;
   assign bus.bullet_active = bullet_active_q;
   assign bus.frame_tick    = frame_tick_q;
   assign bus.busy          = busy_q;

endmodule

// File: tb/tb_player_frame_sched.sv
// Randomized bench for player_frame_sched: a frame-level game model is checked
// against the DUT every cycle, plus literal checkpoints from hand-worked frames.
module tb_player_frame_sched;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int PSIZE    = 16;
   localparam int PSTEP    = 2;

   logic clk_50MHz = 1'b0;
   logic reset     = 1'b0;
   always #10 clk_50MHz = ~clk_50MHz;

   player_frame_sched_if bus ();

   player_frame_sched dut (
      .clk_50MHz (clk_50MHz),
      .reset     (reset),
      .bus       (bus)
   );

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;
   int busy_cnt   = 0;
   int ft_cnt     = 0;
   bit phase      = 1'b1;

   // frame-level model: committed state, pending result, accept edge
   int m_px = 312, m_py = 448, m_bx = 0, m_by = 0;
   bit m_act = 1'b0, m_sprev = 1'b0, m_ft = 1'b0;
   int n_px, n_py, n_bx, n_by;
   bit n_act;
   int m_go = -1;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Whole-frame game rule applied to the committed state.
   task automatic plan_frame(input bit u, input bit d, input bit l, input bit r, input bit s);
      n_px = m_px; n_py = m_py; n_bx = m_bx; n_by = m_by; n_act = m_act;
      if (l && !r) begin n_px = m_px - PSTEP; if (n_px < 0) n_px = 0; end
      if (r && !l) begin n_px = m_px + PSTEP; if (n_px > H_ACTIVE - PSIZE) n_px = H_ACTIVE - PSIZE; end
      if (u && !d) begin n_py = m_py - PSTEP; if (n_py < 0) n_py = 0; end
      if (d && !u) begin n_py = m_py + PSTEP; if (n_py > V_ACTIVE - PSIZE) n_py = V_ACTIVE - PSIZE; end
      if (s && !m_sprev && !m_act && n_py >= 8) begin
         n_bx = n_px + 6; n_by = n_py - 8; n_act = 1'b1;
      end else if (m_act) begin
         if (m_by >= 4) n_by = m_by - 4;
         else n_act = 1'b0;
      end
      m_sprev = s;
   endtask

   task automatic model_edge();
      cyc++;
      if (!reset) begin
         m_px = 312; m_py = 448; m_bx = 0; m_by = 0; m_act = 1'b0;
         m_sprev = 1'b0; m_ft = 1'b0; m_go = -1;
      end else begin
         if (m_go < 0 && m_ft) begin
            m_go = cyc;
            plan_frame(bus.up, bus.down, bus.left, bus.right, bus.shot);
         end else if (m_go >= 0 && cyc == m_go + 5) begin
            m_px = n_px; m_py = n_py; m_bx = n_bx; m_by = n_by; m_act = n_act;
            m_go = -1;
         end
         m_ft = bus.p_tick && bus.x == 10'd0 && bus.y == 10'(V_ACTIVE);
      end
   endtask

   task automatic compare_all();
      chk("frame_tick",    int'(bus.frame_tick),    int'(m_ft));
      chk("busy",          int'(bus.busy),          int'(m_go >= 0));
      chk("player_x",      int'(bus.player_x),      m_px);
      chk("player_y",      int'(bus.player_y),      m_py);
      chk("bullet_x",      int'(bus.bullet_x),      m_bx);
      chk("bullet_y",      int'(bus.bullet_y),      m_by);
      chk("bullet_active", int'(bus.bullet_active), int'(m_act));
   endtask

   task automatic tick();
      @(posedge clk_50MHz);
      model_edge();
      @(negedge clk_50MHz);
      compare_all();
      if (bus.busy) busy_cnt++;
      if (bus.frame_tick) ft_cnt++;
   endtask

   // Random scan position and button noise; occasional near-miss at x=0,y=480.
   task automatic idle_in();
      bus.p_tick = phase;
      phase      = !phase;
      bus.x      = 10'($urandom_range(0, 799));
      bus.y      = 10'($urandom_range(0, 524));
      if (bus.x == 10'd0 && bus.y == 10'd480) bus.y = 10'd479;
      if (!bus.p_tick && $urandom_range(0, 7) == 0) begin
         bus.x = 10'd0; bus.y = 10'd480;
      end
      {bus.up, bus.down, bus.left, bus.right, bus.shot} = 5'($urandom);
   endtask

   // btn = {up,down,left,right,shot}; rst_at>=0 pulses reset inside the frame.
   task automatic frame(input logic [4:0] btn, input int rst_at);
      int gap;
      if (!phase) begin idle_in(); tick(); end
      idle_in(); bus.x = 10'd0; bus.y = 10'd480; tick();
      idle_in(); {bus.up, bus.down, bus.left, bus.right, bus.shot} = btn; tick();
      gap = 6 + $urandom_range(0, 4);
      for (int i = 0; i < gap; i++) begin
         idle_in();
         reset = (i == rst_at) ? 1'b0 : 1'b1;
         tick();
      end
      reset = 1'b1;
   endtask

   task automatic frames(input logic [4:0] btn, input int n);
      for (int i = 0; i < n; i++) frame(btn, -1);
   endtask

   task automatic lit_pos(input string tag, input int ex, input int ey);
      chk({tag, "_px"}, int'(bus.player_x), ex);
      chk({tag, "_py"}, int'(bus.player_y), ey);
   endtask

   task automatic lit_bul(input string tag, input int ebx, input int eby, input int eact);
      chk({tag, "_bx"},  int'(bus.bullet_x), ebx);
      chk({tag, "_by"},  int'(bus.bullet_y), eby);
      chk({tag, "_act"}, int'(bus.bullet_active), eact);
   endtask

   initial begin
      logic [4:0] mode;
      logic [4:0] btn;
      int         rst_at;

      reset = 1'b0;
      repeat (3) begin idle_in(); tick(); end
      reset = 1'b1;
      lit_pos("reset", 312, 448);
      lit_bul("reset", 0, 0, 0);
      chk("reset_busy", int'(bus.busy), 0);

      busy_cnt = 0; ft_cnt = 0;
      frame(5'b00000, -1);
      chk("idle_busy_len", busy_cnt, 5);
      chk("idle_ft_count", ft_cnt, 1);
      frame(5'b00000, -1);
      lit_pos("idle", 312, 448);

      frame(5'b00001, -1);  lit_bul("spawn", 318, 440, 1);
      frame(5'b00001, -1);  lit_bul("adv1", 318, 436, 1);
      frame(5'b00001, -1);  lit_bul("adv2", 318, 432, 1);
      frames(5'b00001, 8);  lit_bul("held", 318, 400, 1);
      frame(5'b00000, -1);  lit_bul("release", 318, 396, 1);
      frame(5'b00001, -1);  lit_bul("press_active", 318, 392, 1);

      frame(5'b00011, -1);  lit_pos("right1", 314, 448);
      frame(5'b00011, -1);  lit_pos("right2", 316, 448);
      frame(5'b00011, -1);  lit_pos("right3", 318, 448);

      frames(5'b00000, 95); lit_bul("last_step", 318, 0, 1);
      frame(5'b00001, -1);  lit_bul("expire", 318, 0, 0);

      frames(5'b00010, 152); lit_pos("right_622", 622, 448);
      frame(5'b00010, -1);   lit_pos("right_624", 624, 448);
      frame(5'b00010, -1);   lit_pos("right_clamp", 624, 448);
      frames(5'b00100, 311); lit_pos("left_2", 2, 448);
      frame(5'b00100, -1);   lit_pos("left_0", 0, 448);
      frame(5'b00100, -1);   lit_pos("left_clamp", 0, 448);
      frame(5'b00010, -1);
      frame(5'b00110, -1);   lit_pos("left_right", 2, 448);
      frames(5'b01000, 8);   lit_pos("down_464", 2, 464);
      frame(5'b01000, -1);   lit_pos("down_clamp", 2, 464);

      // reset while the sequencer sits in MOVE_Y
      if (!phase) begin idle_in(); tick(); end
      idle_in(); bus.x = 10'd0; bus.y = 10'd480; tick();
      idle_in(); {bus.up, bus.down, bus.left, bus.right, bus.shot} = 5'b00010; tick();
      idle_in(); tick();
      idle_in(); reset = 1'b0; tick();
      lit_pos("mid_reset", 312, 448);
      chk("mid_reset_busy", int'(bus.busy), 0);
      reset = 1'b1;
      repeat (4) begin idle_in(); tick(); end
      frame(5'b00010, -1);   lit_pos("after_reset", 314, 448);

      mode = 5'b00000;
      for (int f = 0; f < 250; f++) begin
         if ($urandom_range(0, 19) == 0) mode = 5'($urandom);
         btn = mode;
         if ($urandom_range(0, 3) == 0) btn = btn ^ 5'(1 << $urandom_range(0, 4));
         btn[0] = 1'($urandom_range(0, 1));
         rst_at = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 5)) : -1;
         frame(btn, rst_at);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
